// File: rtl/ibuf2mac_if.sv
// 64-bit AXI4-Stream TX bundle between ibuf2mac and the 10G MAC.
interface ibuf2mac_if;
    logic [63:0] tdata;
    logic [7:0]  tstrb;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic        tuser;

    modport master (output tdata, tstrb, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tstrb, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/ibuf2mac.sv
// Drains committed frames out of ibuf onto the MAC TX AXI4-Stream and hands
// consumed qword space back to the producer through committed_cons.
module ibuf2mac #(
    parameter int BW      = 9,
    parameter int MAX_LEN = 1518
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [BW:0]   committed_prod,
    output logic [BW:0]   committed_cons,
    output logic [BW-1:0] rd_addr,
    input  logic [63:0]   rd_data,
    ibuf2mac_if.master    m_axis,
    output logic          err_len,
    output logic [31:0]   tx_frames
);
    localparam int PW = BW + 1;

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_CHECK, S_STREAM, S_COMMIT} state_t;

    state_t      r_state, w_state_nxt;
    logic [BW:0] r_cons, r_rptr, r_committed_cons;
    logic [15:0] r_len;
    logic [16:0] r_nqw, r_rem, r_beats;
    logic [63:0] r_buf0, r_buf1;
    logic [1:0]  r_cnt;
    logic        r_dat_vld;
    logic        r_err_len;
    logic [31:0] r_tx_frames;

    logic [BW:0] w_occ, w_adv;
    logic [17:0] w_need;
    logic        w_fits, w_drop, w_start, w_done;
    logic        w_tvalid, w_last, w_pop, w_push, w_issue;
    logic [16:0] w_hdr_nqw;
    logic [7:0]  w_strb_last;

    assign w_occ       = committed_prod - r_cons;
    assign w_need      = 18'(r_nqw) + 18'd1;
    assign w_fits      = 18'(w_occ) >= w_need;
    assign w_adv       = r_cons + PW'(w_need);
    assign w_hdr_nqw   = (17'(rd_data[15:0]) + 17'd7) >> 3;
    assign w_strb_last = (r_len[2:0] == 3'd0) ? 8'hFF : ((8'h01 << r_len[2:0]) - 8'h01);

    assign w_tvalid = (r_state == S_STREAM) && (r_cnt != 2'd0);
    assign w_last   = w_tvalid && (r_beats == 17'd1);
    assign w_pop    = w_tvalid && m_axis.tready;
    assign w_push   = r_dat_vld;
    // A read lands in the buffer two edges after issue, so reserve its slot now.
    assign w_issue  = (r_state == S_STREAM) && (r_rem != 17'd0) &&
                      (3'(r_cnt) + 3'(w_push) + 3'd1 <= 3'd2 + 3'(w_pop));

    // Outside STREAM the address sits on cons so the header is ready in HDR.
    assign rd_addr = (r_state == S_STREAM) ? r_rptr[BW-1:0] : r_cons[BW-1:0];

    always_comb begin
        w_state_nxt = r_state;
        w_drop      = 1'b0;
        w_start     = 1'b0;
        w_done      = 1'b0;
        unique case (r_state)
            S_IDLE:   if (w_occ != '0) w_state_nxt = S_HDR;
            S_HDR:    w_state_nxt = S_CHECK;
            S_CHECK: begin
                if (r_len == 16'd0) begin
                    w_drop      = 1'b1;
                    w_state_nxt = S_COMMIT;
                end else if (w_fits) begin
                    if (r_len > 16'(MAX_LEN)) begin
                        w_drop      = 1'b1;
                        w_state_nxt = S_COMMIT;
                    end else begin
                        w_start     = 1'b1;
                        w_state_nxt = S_STREAM;
                    end
                end
            end
            S_STREAM: if (w_pop && w_last) begin
                w_done      = 1'b1;
                w_state_nxt = S_COMMIT;
            end
            S_COMMIT: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state          <= S_IDLE;
            r_cons           <= '0;
            r_rptr           <= '0;
            r_committed_cons <= '0;
            r_len            <= '0;
            r_nqw            <= '0;
            r_rem            <= '0;
            r_beats          <= '0;
            r_buf0           <= '0;
            r_buf1           <= '0;
            r_cnt            <= '0;
            r_dat_vld        <= 1'b0;
            r_err_len        <= 1'b0;
            r_tx_frames      <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_err_len <= w_drop;
            r_dat_vld <= w_issue;

            if (r_state == S_HDR) begin
                r_len <= rd_data[15:0];
                r_nqw <= w_hdr_nqw;
            end
            if (w_drop || w_done) r_cons <= w_adv;
            if (w_done) r_tx_frames <= r_tx_frames + 32'd1;
            if (r_state == S_COMMIT) r_committed_cons <= r_cons;

            if (w_start) begin
                r_rptr  <= r_cons + PW'(1);
                r_rem   <= r_nqw;
                r_beats <= r_nqw;
            end
            if (w_issue) begin
                r_rptr <= r_rptr + PW'(1);
                r_rem  <= r_rem - 17'd1;
            end
            if (w_pop) r_beats <= r_beats - 17'd1;

            // Two-entry skid buffer; r_buf0 is always the head beat on the bus.
            unique case ({w_push, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) r_buf0 <= rd_data;
                    else               r_buf1 <= rd_data;
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_buf0 <= r_buf1;
                    r_cnt  <= r_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_cnt == 2'd1) begin
                        r_buf0 <= rd_data;
                    end else begin
                        r_buf0 <= r_buf1;
                        r_buf1 <= rd_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign committed_cons = r_committed_cons;
    assign err_len        = r_err_len;
    assign tx_frames      = r_tx_frames;

    assign m_axis.tdata  = r_buf0;
    assign m_axis.tvalid = w_tvalid;
    assign m_axis.tlast  = w_last;
    assign m_axis.tstrb  = w_tvalid ? (w_last ? w_strb_last : 8'hFF) : 8'h00;
    assign m_axis.tuser  = 1'b0;
endmodule
